wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Two-requester wishbone arbiter with a transaction watchdog, placed in front of
//  the bus dispatch requester port. It shares the single downstream bus between a
//  host command interface (m0) and an internal sequencer (m1).
//  - Round-robin grant; the owner keeps the bus for the whole cycle (cyc held).
//  - A stalled slave is terminated after TIMEOUT cycles with a synthetic ack.
//  - Timeouts are counted for diagnostics.
// PARAMETERS
//  TIMEOUT  255  cycles stb_o may be high without ack_i before forced termination (1..255)
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  m0_wb_stb_i     in   1   master 0 strobe
//  m0_wb_cyc_i     in   1   master 0 cycle
//  m0_wb_we_i      in   1   master 0 write enable
//  m0_wb_adr_i     in   16  master 0 address
//  m0_wb_dat_i     in   8   master 0 write data
//  m0_wb_dat_o     out  8   master 0 read data
//  m0_wb_ack_o     out  1   master 0 ack
//  m1_wb_*         -    -   same seven signals for master 1
//  wb_stb_o        out  1   downstream strobe
//  wb_cyc_o        out  1   downstream cycle
//  wb_we_o         out  1   downstream write enable
//  wb_adr_o        out  16  downstream address
//  wb_dat_o        out  8   downstream write data
//  wb_dat_i        in   8   downstream read data
//  wb_ack_i        in   1   downstream ack
//  timeout_o       out  1   sticky flag: at least one timeout since clear
//  timeout_cnt_o   out  8   timeouts since clear, saturates at 255
//  timeout_clr_i   in   1   clears timeout_o and timeout_cnt_o (synchronous)
// BEHAVIOUR
//  Reset: state IDLE, priority m0, counters 0; every output 0.
//  States: IDLE, BUSY, TERM.
//  - IDLE: request = mN_cyc_i & mN_stb_i, sampled at a clock edge.
//    - Only one requester: that master is granted.
//    - Both requesting: the master that does not hold priority loses.
//    - The granted master is registered into owner; next state BUSY.
//    - Downstream outputs are 0 in IDLE, so grant latency is 1 clock.
//  - BUSY: cyc_o, stb_o, we_o, adr_o and dat_o come combinationally from the owner.
//    - Owner ack_o = wb_ack_i and owner dat_o = wb_dat_i, both combinational.
//    - Non-owner ack_o and dat_o are 0.
//    - The owner may issue several strobes while it holds cyc.
//    - Owner drops cyc_i: go to IDLE and give priority to the other master.
//      One dead cycle follows before the next grant.
//  - Watchdog counter:
//    - Increments each cycle stb_o=1 and wb_ack_i=0.
//    - Clears on ack_i, or whenever stb_o=0.
//    - Reaching TIMEOUT: go to TERM.
//  - TERM (one cycle):
//    - Downstream stb_o=0 and cyc_o=0, which aborts the slave transfer.
//    - Owner ack_o=1 with dat_o=8'hff.
//    - timeout_o is set and timeout_cnt_o increments (saturating).
//    - Next state BUSY if the owner still holds cyc, else IDLE with the priority swap.
//  - Simultaneous events:
//    - ack_i in the cycle the count would reach TIMEOUT: real ack wins, no timeout.
//    - timeout_clr_i with a timeout event: the clear wins.
//    - Owner drops cyc while stb is pending without ack: release immediately, no ack.
//  - Reset mid-transaction: all outputs drop asynchronously. The aborted master receives no ack.
// TESTING
//  - m0 reads 0x8012 alone, slave acks after 2 cycles with 0x5a
//    -> wb_stb_o rises 1 clk after request; m0_ack_o=1 with m0_dat_o=0x5a; m1_ack_o=0.
//  - m0 and m1 request in the same cycle after reset -> m0 granted first.
//    After m0 drops cyc: 1 idle clk, then m1 granted with adr_o = m1 address.
//  - m1 holds cyc for 3 back-to-back writes while m0 requests
//    -> all 3 complete on m1; m0 granted only after m1 releases.
//  - TIMEOUT=4, slave never acks -> stb_o high for 4 clks, then TERM.
//    In TERM: m0_ack_o=1, dat=0xff, timeout_o=1, timeout_cnt_o=1.
//  - Ack arrives on the TIMEOUT cycle -> normal ack, timeout_cnt_o unchanged.
//    Then pulse timeout_clr_i -> flag and count return to 0.
//  - Assert rst_n=0 during a BUSY transfer -> all outputs 0 immediately.
//    After release, m0 has priority again.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Two-master round-robin Wishbone arbiter with a stalled-slave
//            watchdog that forces a synthetic 0xFF ack after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_we_i,
  input  logic [15:0] m0_wb_adr_i,
  input  logic [7:0]  m0_wb_dat_i,
  output logic [7:0]  m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  // master 1
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_we_i,
  input  logic [15:0] m1_wb_adr_i,
  input  logic [7:0]  m1_wb_dat_i,
  output logic [7:0]  m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  // downstream
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  // diagnostics
  output logic        timeout_o,
  output logic [7:0]  timeout_cnt_o,
  input  logic        timeout_clr_i
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX   = 8'hff;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TERM = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = m0, 1 = m1
  logic        prio_q,  prio_d;    // master that wins a simultaneous request
  logic [7:0]  wdog_q,  wdog_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  tcnt_q,  tcnt_d;

  logic        req0, req1;
  logic        own_cyc, own_stb, own_we;
  logic [15:0] own_adr;
  logic [7:0]  own_dat;
  logic        ret_ack;
  logic [7:0]  ret_dat;
  logic        tevent;

  assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1 = m1_wb_cyc_i & m1_wb_stb_i;

  assign own_cyc = owner_q ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign own_stb = owner_q ? m1_wb_stb_i : m0_wb_stb_i;
  assign own_we  = owner_q ? m1_wb_we_i  : m0_wb_we_i;
  assign own_adr = owner_q ? m1_wb_adr_i : m0_wb_adr_i;
  assign own_dat = owner_q ? m1_wb_dat_i : m0_wb_dat_i;

  // Strobe is qualified by cyc so an owner that drops cyc mid-transfer
  // releases the slave in the same cycle.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    if (state_q == S_BUSY) begin
      wb_cyc_o = own_cyc;
      wb_stb_o = own_cyc & own_stb;
      wb_we_o  = own_we;
      wb_adr_o = own_adr;
      wb_dat_o = own_dat;
    end
  end

  always_comb begin
    ret_ack = 1'b0;
    ret_dat = '0;
    case (state_q)
      S_BUSY: begin
        ret_ack = wb_ack_i & own_cyc;
        ret_dat = wb_dat_i;
      end
      S_TERM: begin
        ret_ack = 1'b1;
        ret_dat = 8'hff;
      end
      default: ;
    endcase
  end

  assign m0_wb_ack_o = ret_ack & ~owner_q;
  assign m0_wb_dat_o = owner_q ? 8'h00 : ret_dat;
  assign m1_wb_ack_o = ret_ack & owner_q;
  assign m1_wb_dat_o = owner_q ? ret_dat : 8'h00;

  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = tcnt_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    tcnt_d    = tcnt_q;
    tevent    = 1'b0;

    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (req0 | req1) begin
          state_d = S_BUSY;
          owner_d = (req0 & req1) ? prio_q : req1;
        end
      end
      S_BUSY: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          prio_d  = ~owner_q;
          wdog_d  = '0;
        end else if (wb_stb_o && !wb_ack_i) begin
          // A real ack on the final cycle takes the else branch and wins.
          if (wdog_q == WDOG_LAST) begin
            state_d = S_TERM;
            wdog_d  = '0;
            tevent  = 1'b1;
          end else begin
            wdog_d = wdog_q + 8'd1;
          end
        end else begin
          wdog_d = '0;
        end
      end
      S_TERM: begin
        wdog_d = '0;
        if (own_cyc) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        wdog_d  = '0;
      end
    endcase

    if (timeout_clr_i) begin
      timeout_d = 1'b0;
      tcnt_d    = '0;
    end else if (tevent) begin
      timeout_d = 1'b1;
      if (tcnt_q != CNT_MAX) begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

endmodule
`default_nettype wire
